// File: rtl/montgomery_exp_if.sv
// Bus between the exponentiation controller (master) and the Montgomery multiplier (slave).
interface montgomery_exp_if #(
    parameter int WIDTH = 1024
);
    logic             mul_start;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_m;
    logic [WIDTH-1:0] mul_result;
    logic             mul_done;

    modport master (
        output mul_start,
        output mul_a,
        output mul_b,
        output mul_m,
        input  mul_result,
        input  mul_done
    );

    modport slave (
        input  mul_start,
        input  mul_a,
        input  mul_b,
        input  mul_m,
        output mul_result,
        output mul_done
    );
endinterface

// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply controller computing X^E mod M on top of an external
// Montgomery multiplier, with a final conditional subtraction so the result is below M.
//
// state           | meaning
// ----------------+------------------------------------------------------------
// S_IDLE          | waiting for start; operands latched on the accepting edge
// S_TOMONT_ISSUE  | pulse mul_start for xm = MM(X, R2)
// S_TOMONT_WAIT   | wait for mul_done, capture xm
// S_SQ_ISSUE      | pulse mul_start for acc = MM(acc, acc)
// S_SQ_WAIT       | wait for mul_done, capture acc, pick MUL / next SQ / FROMMONT
// S_MUL_ISSUE     | pulse mul_start for acc = MM(acc, xm), taken only when E[i]=1
// S_MUL_WAIT      | wait for mul_done, capture acc, pick next SQ / FROMMONT
// S_FROM_ISSUE    | pulse mul_start for acc = MM(acc, 1)
// S_FROM_WAIT     | wait for mul_done, capture acc
// S_FIX           | result = acc >= M ? acc - M : acc
// S_DONE          | done pulse, back to idle
module montgomery_exp #(
    parameter int WIDTH     = 1024,
    parameter int EXP_WIDTH = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [WIDTH-1:0]     in_r2,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    montgomery_exp_if.master     mul
);

    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IW-1:0]    I_TOP = IW'(EXP_WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TOMONT_ISSUE,
        S_TOMONT_WAIT,
        S_SQ_ISSUE,
        S_SQ_WAIT,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_FROM_ISSUE,
        S_FROM_WAIT,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_q;
    state_t               state_nxt;
    logic [EXP_WIDTH-1:0] e_q;
    logic [WIDTH-1:0]     m_q;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     xm;
    logic [IW-1:0]        i_q;
    logic [WIDTH-1:0]     mul_a_q;
    logic [WIDTH-1:0]     mul_b_q;
    logic                 mul_start_c;
    logic                 last_bit;
    logic [WIDTH:0]       fix_diff;

    assign last_bit = (i_q == '0);
    assign fix_diff = {1'b0, acc} - {1'b0, m_q};

    assign mul.mul_start = mul_start_c;
    assign mul.mul_a     = mul_a_q;
    assign mul.mul_b     = mul_b_q;
    assign mul.mul_m     = m_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        mul_start_c = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_TOMONT_ISSUE;
                end
            end
            S_TOMONT_ISSUE: begin
                mul_start_c = 1'b1;
                state_nxt   = S_TOMONT_WAIT;
            end
            S_TOMONT_WAIT: begin
                if (mul.mul_done) begin
                    state_nxt = S_SQ_ISSUE;
                end
            end
            S_SQ_ISSUE: begin
                mul_start_c = 1'b1;
                state_nxt   = S_SQ_WAIT;
            end
            S_SQ_WAIT: begin
                if (mul.mul_done) begin
                    if (e_q[i_q]) begin
                        state_nxt = S_MUL_ISSUE;
                    end else if (last_bit) begin
                        state_nxt = S_FROM_ISSUE;
                    end else begin
                        state_nxt = S_SQ_ISSUE;
                    end
                end
            end
            S_MUL_ISSUE: begin
                mul_start_c = 1'b1;
                state_nxt   = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (mul.mul_done) begin
                    state_nxt = last_bit ? S_FROM_ISSUE : S_SQ_ISSUE;
                end
            end
            S_FROM_ISSUE: begin
                mul_start_c = 1'b1;
                state_nxt   = S_FROM_WAIT;
            end
            S_FROM_WAIT: begin
                if (mul.mul_done) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operands for the next op are loaded on the same edge that captures the previous result,
    // so every ISSUE cycle already presents registered mul_a/mul_b.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_q     <= '0;
            m_q     <= '0;
            acc     <= '0;
            xm      <= '0;
            i_q     <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            result  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        e_q     <= in_e;
                        m_q     <= in_m;
                        acc     <= in_r;
                        i_q     <= I_TOP;
                        mul_a_q <= in_x;
                        mul_b_q <= in_r2;
                    end
                end
                S_TOMONT_WAIT: begin
                    if (mul.mul_done) begin
                        xm      <= mul.mul_result;
                        mul_a_q <= acc;
                        mul_b_q <= acc;
                    end
                end
                S_SQ_WAIT, S_MUL_WAIT: begin
                    if (mul.mul_done) begin
                        acc     <= mul.mul_result;
                        mul_a_q <= mul.mul_result;
                        case (state_nxt)
                            S_MUL_ISSUE:  mul_b_q <= xm;
                            S_FROM_ISSUE: mul_b_q <= ONE;
                            default:      mul_b_q <= mul.mul_result;
                        endcase
                        // Moving on to the next square means bit i is finished; i > 0 here.
                        if (state_nxt == S_SQ_ISSUE) begin
                            i_q <= i_q - 1'b1;
                        end
                    end
                end
                S_FROM_WAIT: begin
                    if (mul.mul_done) begin
                        acc <= mul.mul_result;
                    end
                end
                S_FIX: begin
                    result <= fix_diff[WIDTH] ? acc : fix_diff[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule
